// File: rtl/axi_ram_pkg.sv
// Shared constants and address helpers for the AXI4 simulation RAM.
// Every address is handled as a 64-bit byte address inside the block.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved burst code and WRAP bursts with an illegal length step as INCR.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'd3 || (burst == BURST_WRAP && !wrap_len_ok(len))) return BURST_INCR;
    return burst;
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // size is log2 of the array word in bytes; burst must already be effective.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] step, nxt, wsize, wbase;
    step  = 64'd1 << size;
    nxt   = (addr & ~(step - 64'd1)) + step;
    wsize = ({56'd0, len} + 64'd1) << size;
    wbase = addr & ~(wsize - 64'd1);
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (nxt == wbase + wsize) ? wbase : nxt;
      default:     return nxt;
    endcase
  endfunction

  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Synchronous 1R1W word array with byte enables; read data is registered
// and holds while ren is low. A same-cycle collision returns the old word.
module axi_ram_mem #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 65536
) (
  input  logic                         clock,
  input  logic                         ren,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata,
  input  logic                         wen,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wbe
);
  localparam int NB = DATA_W / 8;

  logic [NB-1:0][7:0] mem [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (ren) rdata <= mem[raddr];
    if (wen) begin
      for (int b = 0; b < NB; b++)
        if (wbe[b]) mem[waddr][b] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_ram_burst.sv
// AXI4 simulation RAM slave: independent read and write burst engines over a
// 1R1W array, with range checking, ID echo and per-burst/per-beat responses.
module axi_ram_burst import axi_ram_pkg::*; #(
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter int          ID_W      = 4,
  parameter int          MEM_WORDS = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ID_W-1:0]     aw_id,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic [7:0]          aw_len,
  input  logic [2:0]          aw_size,
  input  logic [1:0]          aw_burst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  input  logic                w_last,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [ID_W-1:0]     b_id,
  output logic [1:0]          b_resp,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ID_W-1:0]     ar_id,
  input  logic [ADDR_W-1:0]   ar_addr,
  input  logic [7:0]          ar_len,
  input  logic [2:0]          ar_size,
  input  logic [1:0]          ar_burst,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [ID_W-1:0]     r_id,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  output logic                r_last
);
  localparam int          NB        = DATA_W / 8;
  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [2:0]  LG        = 3'($clog2(NB));
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(NB);

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    return IDX_W'((a - BASE_ADDR) >> LG);
  endfunction

  function automatic logic hit(input logic [63:0] a);
    return in_range(a, BASE_ADDR, MEM_BYTES);
  endfunction

  function automatic logic bad_hdr(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    return (size != LG) || (burst == 2'd3) || (burst == BURST_WRAP && !wrap_len_ok(len));
  endfunction

  // ---------------- read engine ----------------
  logic              r_state;
  logic [63:0]       r_addr, r_next, ar_addr64;
  logic [8:0]        r_cnt;
  logic [7:0]        r_len;
  logic [1:0]        r_burst;
  logic              r_slv, r_oor, r_fire, ar_fire;
  logic              ren;
  logic [IDX_W-1:0]  raddr;
  logic [DATA_W-1:0] mem_rdata;

  assign ar_addr64 = 64'(ar_addr);
  assign ar_ready  = (r_state == R_IDLE);
  assign r_valid   = (r_state == R_BURST);
  assign ar_fire   = ar_valid && ar_ready;
  assign r_fire    = r_valid && r_ready;
  assign r_last    = r_valid && (r_cnt == 9'd0);
  assign r_next    = next_addr(r_addr, r_len, LG, r_burst);

  // The array read for the next beat is launched on the fire of the current one.
  always_comb begin
    ren   = 1'b0;
    raddr = word_idx(r_next);
    if (ar_fire) begin
      ren   = 1'b1;
      raddr = word_idx(ar_addr64);
    end else if (r_fire && !r_last) begin
      ren = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_burst <= BURST_INCR;
      r_slv   <= 1'b0;
      r_oor   <= 1'b1;
    end else if (r_state == R_IDLE) begin
      if (ar_valid) begin
        r_state <= R_BURST;
        r_id    <= ar_id;
        r_addr  <= ar_addr64;
        r_cnt   <= {1'b0, ar_len};
        r_len   <= ar_len;
        r_burst <= eff_burst(ar_burst, ar_len);
        r_slv   <= bad_hdr(ar_size, ar_burst, ar_len);
        r_oor   <= !hit(ar_addr64);
      end
    end else if (r_fire) begin
      if (r_last) begin
        r_state <= R_IDLE;
      end else begin
        r_addr <= r_next;
        r_cnt  <= r_cnt - 9'd1;
        r_oor  <= !hit(r_next);
      end
    end
  end

  // r_oor resets high so the visible data is zero until the first real read.
  assign r_data = r_oor ? '0 : mem_rdata;
  assign r_resp = !r_valid ? RESP_OKAY :
                  r_oor    ? RESP_DECERR :
                  r_slv    ? RESP_SLVERR : RESP_OKAY;

  // ---------------- write engine ----------------
  logic [1:0]  w_state, w_burst, w_resp, w_beat_resp;
  logic [63:0] w_addr, aw_addr64;
  logic [8:0]  w_cnt;
  logic [7:0]  w_len;
  logic        w_final, w_hit;

  assign aw_addr64   = 64'(aw_addr);
  assign aw_ready    = (w_state == W_IDLE);
  assign w_ready     = (w_state == W_DATA);
  assign b_valid     = (w_state == W_RESP);
  assign b_resp      = b_valid ? w_resp : RESP_OKAY;
  assign w_final     = (w_cnt == 9'd0);
  assign w_hit       = hit(w_addr);
  assign w_beat_resp = resp_max(w_hit ? RESP_OKAY : RESP_DECERR,
                                (w_last != w_final) ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state <= W_IDLE;
      b_id    <= '0;
      w_addr  <= '0;
      w_cnt   <= '0;
      w_len   <= '0;
      w_burst <= BURST_INCR;
      w_resp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (aw_valid) begin
          w_state <= W_DATA;
          b_id    <= aw_id;
          w_addr  <= aw_addr64;
          w_cnt   <= {1'b0, aw_len};
          w_len   <= aw_len;
          w_burst <= eff_burst(aw_burst, aw_len);
          w_resp  <= bad_hdr(aw_size, aw_burst, aw_len) ? RESP_SLVERR : RESP_OKAY;
        end
        // Beat count alone ends the burst; w_last only feeds the response.
        W_DATA: if (w_valid) begin
          w_resp <= resp_max(w_resp, w_beat_resp);
          if (w_final) begin
            w_state <= W_RESP;
          end else begin
            w_addr <= next_addr(w_addr, w_len, LG, w_burst);
            w_cnt  <= w_cnt - 9'd1;
          end
        end
        W_RESP: if (b_ready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_ram_mem #(.DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_mem (
    .clock (clock),
    .ren   (ren),
    .raddr (raddr),
    .rdata (mem_rdata),
    .wen   (w_ready && w_valid && w_hit),
    .waddr (word_idx(w_addr)),
    .wdata (w_data),
    .wbe   (w_strb)
  );

endmodule

// File: doc/axi_ram_burst.md
Name: axi_ram_burst

Overview:
- Parametrised AXI4 simulation RAM slave, next generation of the simulation-only AXI RAM behind the core's AXI master.
- Adds honoured rready/bready backpressure, bresp/rresp, ID echo, FIXED/INCR/WRAP bursts, range checking and configurable width/depth.
- Owns its storage through a 1R1W synchronous array sub-module.
- Read and write channels are fully independent.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; power of two, 32..256.
- ID_W, 4, AXI ID width.
- MEM_WORDS, 65536, array depth in DATA_W words; power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- aw_valid/aw_ready  in/out  1  write-address handshake.
- aw_id  in  ID_W.
- aw_addr  in  ADDR_W.
- aw_len  in  8  beats-1.
- aw_size  in  3.
- aw_burst  in  2.
- w_valid/w_ready  in/out  1  write-data handshake.
- w_data  in  DATA_W.
- w_strb  in  DATA_W/8.
- w_last  in  1.
- b_valid/b_ready  out/in  1  write-response handshake.
- b_id  out  ID_W.
- b_resp  out  2.
- ar_valid/ar_ready  in/out  1  read-address handshake.
- ar_id  in  ID_W.
- ar_addr  in  ADDR_W.
- ar_len  in  8.
- ar_size  in  3.
- ar_burst  in  2.
- r_valid/r_ready  out/in  1  read-data handshake.
- r_id  out  ID_W.
- r_data  out  DATA_W.
- r_resp  out  2.
- r_last  out  1.

Behaviour:
- Reset: applied when reset==0 at a rising edge.
  - aw_ready=1, ar_ready=1; w_ready, b_valid, r_valid, r_last = 0; b_resp, r_resp, b_id, r_id = 0; r_data = 0.
  - Reset mid-burst abandons the burst with no response; array contents are retained.
- Word index: (addr-BASE_ADDR)>>log2(DATA_W/8).
  - In range iff BASE_ADDR <= addr < BASE_ADDR+MEM_WORDS*DATA_W/8, checked on every beat.
- Next-beat address:
  - FIXED: unchanged.
  - INCR: (addr aligned down to word)+DATA_W/8; beat 0 uses the word containing an unaligned addr.
  - WRAP: increments within a window of (len+1)*DATA_W/8 bytes, aligned to that size, wrapping to the window base.
- Response codes: OKAY=0, SLVERR=2, DECERR=3. A burst error takes the highest code seen.
  - SLVERR: size != log2(DATA_W/8); burst==3 (treated as INCR); WRAP with len not in {1,3,7,15} (treated as INCR); w_last mismatch.
  - DECERR: any out-of-range beat. That beat is not written; its read data is 0.
- Read FSM, R_IDLE -> R_BURST:
  - R_IDLE: ar_ready=1.
  - AR fire latches id, len, burst, size and issues an array read of ar_addr that same edge; r_valid=1 from the next cycle (1-cycle latency), ar_ready=0.
  - R_BURST: the array read advances only on r fire with r_last=0, giving 1 beat/cycle under continuous r_ready.
  - r_ready=0: r_valid, r_data, r_resp and r_last hold stable.
  - r_last=1 when the remaining count==0. On that beat's r fire, go to R_IDLE; ar_ready=1 the next cycle, r_valid=0.
  - r_resp is per beat.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: aw_ready=1. AW fire latches fields; next cycle w_ready=1.
  - W_DATA: each w fire writes the enabled bytes of w_data under w_strb at the current word, then advances.
  - The burst terminates on the beat counter only (len+1 beats). Early w_last, or missing w_last on the final beat, sets SLVERR; beats are still accepted up to the count.
  - After the final beat: w_ready=0, b_valid=1 the next cycle with b_id=aw_id and the accumulated b_resp.
  - W_RESP: b_valid holds until b_ready. On b fire go to W_IDLE; aw_ready=1 the next cycle.
- Simultaneous read and write to the same word in one cycle: the read returns the old data (read-first).
- The counter is 9 bits; len=255 gives 256 beats with no overflow.

Decomposition:
- Package axi_ram_pkg:
  - burst constants FIXED=0, INCR=1, WRAP=2.
  - resp constants.
  - FSM state enums.
  - function next_addr(addr,len,size,burst).
  - function in_range(addr).
- Sub-module axi_ram_mem: synchronous 1R1W array, MEM_WORDS x DATA_W.
  - Ports: ren, raddr, rdata (registered, held when ren=0), wen, waddr, wdata, wbe.
  - Read-first on collision.

Test Plan:
1. Write INCR, aw_addr=0x8000_0000, len=3, data 0x11..,0x22..,0x33..,0x44.., strb=0xFF -> b_resp=0 after 4 beats. Then read the same burst with r_ready=1 -> r_valid 1 cycle after AR fire, 4 consecutive beats, r_last on beat 4, data matches.
2. Read len=7 with r_ready toggled 1,0,0,1... -> each beat held stable while r_ready=0; 8 beats total; ar_ready reasserts only after the last-beat fire.
3. WRAP read, addr=0x8000_0018, len=3, 64-bit -> addresses 0x18, 0x00, 0x08, 0x10 (offsets); WRAP len=2 -> r_resp=2.
4. Write strb=0x0F over 0xFFFF_FFFF_FFFF_FFFF with data 0 -> readback 0xFFFF_FFFF_0000_0000. Write with w_last on beat 2 of 4 -> b_resp=2, 4 beats written.
5. AW at BASE+MEM_WORDS*8-8, len=1 -> beat 0 written, beat 1 dropped, b_resp=3. Same read -> beat 1 data 0, r_resp=3. b_ready held 0 for 5 cycles -> b_valid held, aw_ready=0.
6. reset=0 mid read burst (beat 2 of 8) -> next cycle r_valid=0, ar_ready=1, aw_ready=1; previously written data still reads back.
